emergency_request_scheduler: RTL and testbench
==============================================

// Module: emergency_request_scheduler
// PURPOSE
//   Qualifies raw ambulance-detector inputs for the NS and EW roads and arbitrates them.
//   Drives the amb_ns/amb_ew priority inputs of the intersection traffic controller.
//   Grants one direction at a time, with a minimum hold and a maximum hold (stuck-detector timeout).
//   Inserts an all-released clearance gap between grants and alternates fairly on contention.
// PARAMETERS
//   DEBOUNCE_CYC  3   consecutive high samples needed to qualify a raw request (>=1)
//   HOLD_CYC      15  minimum grant length in cycles (>=1)
//   MAX_HOLD_CYC  60  grant timeout in cycles; must be > HOLD_CYC
//   CLEAR_CYC     4   cycles with both amb outputs low between grants (>=1)
// PORTS
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   req_ns_raw   in   1  raw NS ambulance detector
//   req_ew_raw   in   1  raw EW ambulance detector
//   enable       in   1  scheduler enable; 0 = no grants
//   amb_ns       out  1  NS priority request to the traffic controller
//   amb_ew       out  1  EW priority request to the traffic controller
//   busy         out  1  1 in any state other than IDLE
//   stuck_err    out  1  sticky: a grant hit MAX_HOLD_CYC with its request still high
//   served_cnt   out  8  count of grants issued, saturating at 255
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, pending flags 0, debounce counters 0, last_served=EW.
//     The last_served=EW reset value makes NS win the first tie.
//   All outputs are registered. amb_ns & amb_ew is never 1.
//   Debounce: a per-direction counter increments while raw=1 and clears on raw=0.
//     q_x=1 while counter >= DEBOUNCE_CYC.
//     q_x drops on the first edge that samples raw=0.
//   Pending: pend_x is set on the edge where q_x goes 0->1.
//     pend_x is cleared when its grant starts.
//     pend_x is forced to 0 while enable=0.
//     A request held high continuously never re-arms pend_x; it must drop and re-qualify.
//   FSM IDLE -> GRANT_NS/GRANT_EW:
//     If enable=1 and a pend_x is set, go to GRANT_x on the next edge.
//     If both are pending, grant the direction != last_served.
//     On grant entry: timer=0, last_served=x, served_cnt+1 (saturating).
//   Latency from IDLE: amb_x=1 on edge DEBOUNCE_CYC+1, counting the first edge that samples raw=1 as edge 0.
//   GRANT_x (amb_x=1), timer increments each cycle:
//     If timer>=HOLD_CYC-1 and q_x=0, go to CLEAR.
//     If timer==MAX_HOLD_CYC-1 and q_x=1, set stuck_err and go to CLEAR.
//     If enable=0, go to CLEAR on the next edge regardless of timer.
//     Other-direction requests arriving during a grant are latched in pend_y and served after CLEAR.
//   CLEAR: both amb outputs are 0 for exactly CLEAR_CYC cycles, then IDLE.
//     Requests that qualify during CLEAR are latched.
//   IDLE -> GRANT is allowed on the edge that leaves CLEAR.
//     A pend_x already set at that edge is granted with no extra IDLE cycle.
//   Counters wrap-safe: timer width is clog2(MAX_HOLD_CYC). served_cnt holds at 8'hFF.
//   stuck_err clears only on rst.
//   Reset mid-grant: on the next edge, amb outputs go to 0, state goes to IDLE, and pending is lost.
//   Unused state encodings return to IDLE with outputs 0.
// TESTING
//   1. req_ns_raw=1 for 6 cycles from edge 0:
//      amb_ns=1 on edges 4..18 (15 cycles), then 0 for 4 cycles; served_cnt=1, busy low at edge 23.
//   2. req_ew_raw pulses of 2 cycles, repeated 5 times with 1-cycle gaps:
//      amb_ew stays 0 and served_cnt=0.
//   3. Both raw inputs rise together after reset, 3-cycle pulses:
//      NS is granted first for 15 cycles, then 4 cycles of CLEAR, then EW for 15.
//      A repeat tie then grants NS first (last_served=EW).
//   4. req_ns_raw held 1 for 100 cycles:
//      amb_ns drops after 60 cycles and stuck_err=1; no regrant until raw goes 0 then 1 for >=3 cycles.
//   5. enable=0 at grant cycle 5:
//      amb_x=0 on the next edge; pend flags are 0; no grant while enable=0, even with raw=1.
//   6. rst=1 at grant cycle 7 with EW pending:
//      all outputs are 0 on the next edge; after release, no grant occurs unless requests re-qualify.

Source files
------------

// File: rtl/emergency_request_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : emergency_request_scheduler_if
// Brief   : Request/grant bundle between detector front end and scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface emergency_request_scheduler_if;
    logic       req_ns_raw;
    logic       req_ew_raw;
    logic       enable;
    logic       amb_ns;
    logic       amb_ew;
    logic       busy;
    logic       stuck_err;
    logic [7:0] served_cnt;

    modport master (
        output req_ns_raw, req_ew_raw, enable,
        input  amb_ns, amb_ew, busy, stuck_err, served_cnt
    );

    modport slave (
        input  req_ns_raw, req_ew_raw, enable,
        output amb_ns, amb_ew, busy, stuck_err, served_cnt
    );
endinterface
`default_nettype wire

// File: rtl/emergency_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : emergency_request_scheduler
// Brief   : Debounces NS/EW ambulance detectors and grants one direction at a
//           time with min/max hold, clearance gap and fair tie alternation.
// Revision: 1.0 - initial release
// ============================================================================
module emergency_request_scheduler #(
    parameter int DEBOUNCE_CYC = 3,
    parameter int HOLD_CYC     = 15,
    parameter int MAX_HOLD_CYC = 60,
    parameter int CLEAR_CYC    = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    emergency_request_scheduler_if.slave bus
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(MAX_HOLD_CYC);
    localparam int CW = $clog2(CLEAR_CYC + 1);

    localparam logic [DW-1:0] c_DEB_MAX   = DW'(DEBOUNCE_CYC);
    localparam logic [TW-1:0] c_HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] c_MAX_LAST  = TW'(MAX_HOLD_CYC - 1);
    localparam logic [CW-1:0] c_CLR_LAST  = CW'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT_NS = 3'd1,
        S_GRANT_EW = 3'd2,
        S_CLEAR    = 3'd3
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_cnt_ns, r_cnt_ew;
    logic          r_q_ns_d, r_q_ew_d;
    logic          r_pend_ns, r_pend_ew;
    logic          r_last_ew;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_clr;
    logic          r_amb_ns, r_amb_ew, r_busy, r_stuck;
    logic [7:0]    r_served;

    logic w_q_ns, w_q_ew, w_rise_ns, w_rise_ew;
    logic w_start, w_pick_ns, w_start_ns, w_start_ew, w_q_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_ns <= '0;
            r_cnt_ew <= '0;
        end else begin
            if (!bus.req_ns_raw)          r_cnt_ns <= '0;
            else if (r_cnt_ns != c_DEB_MAX) r_cnt_ns <= r_cnt_ns + DW'(1);
            if (!bus.req_ew_raw)          r_cnt_ew <= '0;
            else if (r_cnt_ew != c_DEB_MAX) r_cnt_ew <= r_cnt_ew + DW'(1);
        end
    end

    assign w_q_ns    = (r_cnt_ns >= c_DEB_MAX);
    assign w_q_ew    = (r_cnt_ew >= c_DEB_MAX);
    assign w_rise_ns = w_q_ns & ~r_q_ns_d;
    assign w_rise_ew = w_q_ew & ~r_q_ew_d;

    // A grant may start from IDLE or on the very edge that leaves CLEAR.
    assign w_start    = bus.enable & (r_pend_ns | r_pend_ew) &
                        ((r_state == S_IDLE) || ((r_state == S_CLEAR) && (r_clr == c_CLR_LAST)));
    assign w_pick_ns  = r_pend_ns & (~r_pend_ew | r_last_ew);
    assign w_start_ns = w_start & w_pick_ns;
    assign w_start_ew = w_start & ~w_pick_ns;
    assign w_q_cur    = (r_state == S_GRANT_NS) ? w_q_ns : w_q_ew;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_q_ns_d  <= 1'b0;
            r_q_ew_d  <= 1'b0;
            r_pend_ns <= 1'b0;
            r_pend_ew <= 1'b0;
            r_last_ew <= 1'b1;
            r_timer   <= '0;
            r_clr     <= '0;
            r_amb_ns  <= 1'b0;
            r_amb_ew  <= 1'b0;
            r_busy    <= 1'b0;
            r_stuck   <= 1'b0;
            r_served  <= 8'd0;
        end else begin
            r_q_ns_d  <= w_q_ns;
            r_q_ew_d  <= w_q_ew;
            r_pend_ns <= bus.enable & ((r_pend_ns & ~w_start_ns) | w_rise_ns);
            r_pend_ew <= bus.enable & ((r_pend_ew & ~w_start_ew) | w_rise_ew);

            if (w_start) begin
                r_state   <= w_pick_ns ? S_GRANT_NS : S_GRANT_EW;
                r_amb_ns  <= w_pick_ns;
                r_amb_ew  <= ~w_pick_ns;
                r_busy    <= 1'b1;
                r_timer   <= '0;
                r_last_ew <= ~w_pick_ns;
                if (r_served != 8'hFF) r_served <= r_served + 8'd1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_amb_ns <= 1'b0;
                        r_amb_ew <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                    S_GRANT_NS, S_GRANT_EW: begin
                        if ((r_timer == c_MAX_LAST) && w_q_cur) r_stuck <= 1'b1;
                        if (!bus.enable || ((r_timer == c_MAX_LAST) && w_q_cur) ||
                            ((r_timer >= c_HOLD_LAST) && !w_q_cur)) begin
                            r_state  <= S_CLEAR;
                            r_amb_ns <= 1'b0;
                            r_amb_ew <= 1'b0;
                            r_clr    <= '0;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_CLEAR: begin
                        if (r_clr == c_CLR_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_clr <= r_clr + CW'(1);
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_amb_ns <= 1'b0;
                        r_amb_ew <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.amb_ns     = r_amb_ns;
    assign bus.amb_ew     = r_amb_ew;
    assign bus.busy       = r_busy;
    assign bus.stuck_err  = r_stuck;
    assign bus.served_cnt = r_served;

endmodule
`default_nettype wire

// File: tb/tb_emergency_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_emergency_request_scheduler
// Brief   : Directed self-checking bench for emergency_request_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_emergency_request_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   e     = 0;

    always #5 clk = ~clk;

    emergency_request_scheduler_if bus ();

    emergency_request_scheduler #(
        .DEBOUNCE_CYC(3),
        .HOLD_CYC    (15),
        .MAX_HOLD_CYC(60),
        .CLEAR_CYC   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int target);
        while (e < target) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic do_reset();
        bus.req_ns_raw = 1'b0;
        bus.req_ew_raw = 1'b0;
        bus.enable     = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.req_ns_raw = 1'b0;
        bus.req_ew_raw = 1'b0;
        bus.enable     = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_amb_ns", {7'd0, bus.amb_ns}, 8'd0);
        chk("rst_amb_ew", {7'd0, bus.amb_ew}, 8'd0);
        chk("rst_busy",   {7'd0, bus.busy}, 8'd0);
        chk("rst_stuck",  {7'd0, bus.stuck_err}, 8'd0);
        chk("rst_served", bus.served_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // 1: single NS request, 6 cycles
        bus.req_ns_raw = 1'b1;
        e = -1;
        run_to(3);
        chk("t1_latency_e3", {7'd0, bus.amb_ns}, 8'd0);
        run_to(4);
        chk("t1_grant_e4", {7'd0, bus.amb_ns}, 8'd1);
        chk("t1_served", bus.served_cnt, 8'd1);
        run_to(5);
        bus.req_ns_raw = 1'b0;
        for (int k = 6; k <= 18; k++) begin
            run_to(k);
            chk("t1_hold", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd2);
        end
        run_to(19);
        chk("t1_clear_amb", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        chk("t1_clear_busy", {7'd0, bus.busy}, 8'd1);
        run_to(22);
        chk("t1_clear_end_busy", {7'd0, bus.busy}, 8'd1);
        run_to(23);
        chk("t1_idle_busy", {7'd0, bus.busy}, 8'd0);

        // 2: short EW glitches never qualify
        do_reset();
        for (int p = 0; p < 5; p++) begin
            bus.req_ew_raw = 1'b1;
            tick();
            tick();
            bus.req_ew_raw = 1'b0;
            tick();
            chk("t2_amb_ew", {7'd0, bus.amb_ew}, 8'd0);
        end
        tick();
        tick();
        chk("t2_served", bus.served_cnt, 8'd0);
        chk("t2_busy", {7'd0, bus.busy}, 8'd0);

        // 3: tie, NS first, then EW after clearance; repeat tie -> NS first
        do_reset();
        bus.req_ns_raw = 1'b1;
        bus.req_ew_raw = 1'b1;
        e = -1;
        run_to(2);
        bus.req_ns_raw = 1'b0;
        bus.req_ew_raw = 1'b0;
        run_to(4);
        chk("t3_ns_first", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd2);
        run_to(18);
        chk("t3_ns_last", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd2);
        run_to(19);
        chk("t3_clear", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        run_to(22);
        chk("t3_clear_end", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        run_to(23);
        chk("t3_ew_grant", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd1);
        chk("t3_served2", bus.served_cnt, 8'd2);
        run_to(37);
        chk("t3_ew_last", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd1);
        run_to(38);
        chk("t3_ew_drop", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        run_to(42);
        chk("t3_idle", {7'd0, bus.busy}, 8'd0);
        bus.req_ns_raw = 1'b1;
        bus.req_ew_raw = 1'b1;
        e = -1;
        run_to(2);
        bus.req_ns_raw = 1'b0;
        bus.req_ew_raw = 1'b0;
        run_to(4);
        chk("t3_retie_ns", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd2);
        chk("t3_served3", bus.served_cnt, 8'd3);
        run_to(23);
        chk("t3_retie_ew", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd1);
        run_to(42);

        // 4: stuck NS detector
        do_reset();
        bus.req_ns_raw = 1'b1;
        e = -1;
        run_to(4);
        chk("t4_grant", {7'd0, bus.amb_ns}, 8'd1);
        run_to(63);
        chk("t4_hold59", {7'd0, bus.amb_ns}, 8'd1);
        chk("t4_no_stuck_yet", {7'd0, bus.stuck_err}, 8'd0);
        run_to(64);
        chk("t4_timeout_amb", {7'd0, bus.amb_ns}, 8'd0);
        chk("t4_stuck", {7'd0, bus.stuck_err}, 8'd1);
        run_to(99);
        chk("t4_no_regrant", {7'd0, bus.amb_ns}, 8'd0);
        chk("t4_served1", bus.served_cnt, 8'd1);
        bus.req_ns_raw = 1'b0;
        tick();
        tick();
        bus.req_ns_raw = 1'b1;
        e = -1;
        run_to(2);
        bus.req_ns_raw = 1'b0;
        run_to(4);
        chk("t4_regrant", {7'd0, bus.amb_ns}, 8'd1);
        chk("t4_served2", bus.served_cnt, 8'd2);
        chk("t4_stuck_sticky", {7'd0, bus.stuck_err}, 8'd1);
        run_to(23);
        chk("t4_end_idle", {7'd0, bus.busy}, 8'd0);

        // 5: enable dropped mid-grant
        do_reset();
        bus.req_ew_raw = 1'b1;
        e = -1;
        run_to(4);
        chk("t5_grant", {7'd0, bus.amb_ew}, 8'd1);
        run_to(9);
        bus.enable     = 1'b0;
        bus.req_ns_raw = 1'b1;
        run_to(10);
        chk("t5_drop", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        chk("t5_clear_busy", {7'd0, bus.busy}, 8'd1);
        run_to(13);
        chk("t5_clear_end", {7'd0, bus.busy}, 8'd1);
        run_to(14);
        chk("t5_idle", {7'd0, bus.busy}, 8'd0);
        for (int k = 15; k <= 30; k++) begin
            run_to(k);
            chk("t5_disabled", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        end
        bus.enable = 1'b1;
        run_to(35);
        chk("t5_no_stale_pend", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        chk("t5_served", bus.served_cnt, 8'd1);
        bus.req_ns_raw = 1'b0;
        bus.req_ew_raw = 1'b0;

        // 6: reset mid-grant with EW pending
        do_reset();
        bus.req_ns_raw = 1'b1;
        e = -1;
        run_to(2);
        bus.req_ns_raw = 1'b0;
        run_to(4);
        chk("t6_grant", {7'd0, bus.amb_ns}, 8'd1);
        bus.req_ew_raw = 1'b1;
        run_to(7);
        bus.req_ew_raw = 1'b0;
        run_to(11);
        rst = 1'b1;
        run_to(12);
        chk("t6_rst_amb", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        chk("t6_rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("t6_rst_served", bus.served_cnt, 8'd0);
        rst = 1'b0;
        for (int k = 13; k <= 40; k++) begin
            run_to(k);
            chk("t6_pend_lost", {6'd0, bus.amb_ns, bus.amb_ew}, 8'd0);
        end
        bus.req_ew_raw = 1'b1;
        e = -1;
        run_to(2);
        bus.req_ew_raw = 1'b0;
        run_to(3);
        chk("t6_requal_e3", {7'd0, bus.amb_ew}, 8'd0);
        run_to(4);
        chk("t6_requal_grant", {7'd0, bus.amb_ew}, 8'd1);
        chk("t6_served", bus.served_cnt, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
